// File: rtl/riscv_pkg.sv
// Shared control-path types for the five-stage RV32I core: result selects,
// forwarding selects and the per-stage control words carried down the pipeline.
package riscv_pkg;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_control;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [4:0] rd;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } ctrl_w_t;

  // Memory-stage result is younger than Writeback, so it wins when both match.
  function automatic fwd_sel_t fwd_select(input logic [4:0] rs_e,
                                          input logic       reg_write_m,
                                          input logic [4:0] rd_m,
                                          input logic       reg_write_w,
                                          input logic [4:0] rd_w);
    fwd_select = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rs_e == rd_m)) begin
      fwd_select = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rs_e == rd_w)) begin
      fwd_select = FWD_WB;
    end
  endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Controller/datapath-facing bundle of ctrl_pipeline: decode-stage control in,
// stage-register control, hazard and forwarding selects and debug counters out.
interface ctrl_pipeline_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [1:0]       ResultSrcD;
  logic             MemWriteD;
  logic             ALUSrcD;
  logic             RegWriteD;
  logic             JumpD;
  logic             BranchD;
  logic [2:0]       ALUControlD;
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdD;
  logic             ZeroE;

  logic             ALUSrcE;
  logic [2:0]       ALUControlE;
  logic             PCSrcE;
  logic             MemWriteM;
  logic [1:0]       ResultSrcW;
  logic             RegWriteW;
  logic [4:0]       RdW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ResultSrcD, MemWriteD, ALUSrcD, RegWriteD, JumpD, BranchD,
           ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
    input  ALUSrcE, ALUControlE, PCSrcE, MemWriteM, ResultSrcW, RegWriteW,
           RdW, ForwardAE, ForwardBE, StallF, StallD, FlushD,
           StallCount, FlushCount
  );

  modport slave (
    input  ResultSrcD, MemWriteD, ALUSrcD, RegWriteD, JumpD, BranchD,
           ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
    output ALUSrcE, ALUControlE, PCSrcE, MemWriteM, ResultSrcW, RegWriteW,
           RdW, ForwardAE, ForwardBE, StallF, StallD, FlushD,
           StallCount, FlushCount
  );
endinterface

// File: rtl/ctrl_pipeline_hazard.sv
// Combinational hazard logic: load-use stall, branch/jump redirect and flush,
// and ALU operand forwarding selects.
module hazard_unit
  import riscv_pkg::*;
(
  input  logic [1:0] result_src_e,
  input  logic [4:0] rd_e,
  input  logic       branch_e,
  input  logic       jump_e,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic       zero_e,
  input  logic       reg_write_m,
  input  logic [4:0] rd_m,
  input  logic       reg_write_w,
  input  logic [4:0] rd_w,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  output logic       lw_stall,
  output logic       pc_src,
  output logic       flush_d,
  output logic       flush_e,
  output logic       stall_f,
  output logic       stall_d,
  output fwd_sel_t   forward_a,
  output fwd_sel_t   forward_b
);

  always_comb begin
    lw_stall = (result_src_e == RESULT_LOAD) && (rd_e != '0) &&
               ((rs1_d == rd_e) || (rs2_d == rd_e));
    pc_src   = (branch_e && zero_e) || jump_e;
    // Stall outputs stay asserted alongside a redirect; the PC mux prefers PCSrcE.
    stall_f  = lw_stall;
    stall_d  = lw_stall;
    flush_d  = pc_src;
    flush_e  = lw_stall || pc_src;
    forward_a = fwd_select(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    forward_b = fwd_select(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Execute/Memory/Writeback control pipeline registers with hazard detection,
// forwarding selects and saturating stall/flush debug counters.
module ctrl_pipeline
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  ctrl_pipeline_if.slave  bus
);

  ctrl_e_t          ctrl_e_d, ctrl_e_q;
  ctrl_m_t          ctrl_m_d, ctrl_m_q;
  ctrl_w_t          ctrl_w_d, ctrl_w_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  logic             lw_stall, pc_src, flush_d, flush_e, stall_f, stall_d;
  fwd_sel_t         forward_a, forward_b;

  hazard_unit u_hazard (
    .result_src_e (ctrl_e_q.result_src),
    .rd_e         (ctrl_e_q.rd),
    .branch_e     (ctrl_e_q.branch),
    .jump_e       (ctrl_e_q.jump),
    .rs1_e        (ctrl_e_q.rs1),
    .rs2_e        (ctrl_e_q.rs2),
    .zero_e       (bus.ZeroE),
    .reg_write_m  (ctrl_m_q.reg_write),
    .rd_m         (ctrl_m_q.rd),
    .reg_write_w  (ctrl_w_q.reg_write),
    .rd_w         (ctrl_w_q.rd),
    .rs1_d        (bus.Rs1D),
    .rs2_d        (bus.Rs2D),
    .lw_stall     (lw_stall),
    .pc_src       (pc_src),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .forward_a    (forward_a),
    .forward_b    (forward_b)
  );

  always_comb begin
    ctrl_e_d = '0;
    if (!flush_e) begin
      ctrl_e_d.reg_write   = bus.RegWriteD;
      ctrl_e_d.result_src  = bus.ResultSrcD;
      ctrl_e_d.mem_write   = bus.MemWriteD;
      ctrl_e_d.jump        = bus.JumpD;
      ctrl_e_d.branch      = bus.BranchD;
      ctrl_e_d.alu_src     = bus.ALUSrcD;
      ctrl_e_d.alu_control = bus.ALUControlD;
      ctrl_e_d.rs1         = bus.Rs1D;
      ctrl_e_d.rs2         = bus.Rs2D;
      ctrl_e_d.rd          = bus.RdD;
    end

    ctrl_m_d.reg_write  = ctrl_e_q.reg_write;
    ctrl_m_d.result_src = ctrl_e_q.result_src;
    ctrl_m_d.mem_write  = ctrl_e_q.mem_write;
    ctrl_m_d.rd         = ctrl_e_q.rd;

    ctrl_w_d.reg_write  = ctrl_m_q.reg_write;
    ctrl_w_d.result_src = ctrl_m_q.result_src;
    ctrl_w_d.rd         = ctrl_m_q.rd;

    // Counters hold at all-ones rather than wrapping.
    stall_cnt_d = stall_cnt_q;
    if (lw_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (pc_src && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e_q    <= '0;
      ctrl_m_q    <= '0;
      ctrl_w_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_e_q    <= ctrl_e_d;
      ctrl_m_q    <= ctrl_m_d;
      ctrl_w_q    <= ctrl_w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ALUSrcE     = ctrl_e_q.alu_src;
  assign bus.ALUControlE = ctrl_e_q.alu_control;
  assign bus.PCSrcE      = pc_src;
  assign bus.MemWriteM   = ctrl_m_q.mem_write;
  assign bus.ResultSrcW  = ctrl_w_q.result_src;
  assign bus.RegWriteW   = ctrl_w_q.reg_write;
  assign bus.RdW         = ctrl_w_q.rd;
  assign bus.ForwardAE   = forward_a;
  assign bus.ForwardBE   = forward_b;
  assign bus.StallF      = stall_f;
  assign bus.StallD      = stall_d;
  assign bus.FlushD      = flush_d;
  assign bus.StallCount  = stall_cnt_q;
  assign bus.FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: a full-width and a 2-bit-counter instance
// share stimulus and are compared against an instruction-level pipeline model.
module tb_ctrl_pipeline;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipeline_if #(.CNT_W(16)) bus_w ();
  ctrl_pipeline_if #(.CNT_W(2))  bus_n ();

  ctrl_pipeline #(.CNT_W(16)) u_dut_w (.clk(clk), .reset(rst), .bus(bus_w));
  ctrl_pipeline #(.CNT_W(2))  u_dut_n (.clk(clk), .reset(rst), .bus(bus_n));

  typedef struct {
    bit       rw;
    bit [1:0] res;
    bit       mw;
    bit       jmp;
    bit       br;
    bit       asrc;
    bit [2:0] alu;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
  } instr_t;

  // Instruction-level model: pipe[0]=Execute, pipe[1]=Memory, pipe[2]=Writeback.
  instr_t      pipe [3];
  instr_t      cur;
  instr_t      nop_i;
  bit          zero;
  bit          model_valid;
  int unsigned stall_events, flush_events;
  int unsigned n_checks, n_errors;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_pcsrc();
    return (pipe[0].br && zero) || pipe[0].jmp;
  endfunction

  function automatic bit exp_lw();
    return (pipe[0].res == 2'b01) && (pipe[0].rd != 0) &&
           ((cur.rs1 == pipe[0].rd) || (cur.rs2 == pipe[0].rd));
  endfunction

  function automatic int unsigned exp_fwd(input bit [4:0] src);
    if (pipe[1].rw && pipe[1].rd != 0 && pipe[1].rd == src) return 2;
    if (pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == src) return 1;
    return 0;
  endfunction

  function automatic int unsigned sat(input int unsigned n, input int unsigned mx);
    return (n > mx) ? mx : n;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.rw   = 1'($urandom_range(0, 1));
    i.res  = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom_range(0, 2));
    i.mw   = 1'($urandom_range(0, 1));
    i.jmp  = ($urandom_range(0, 9) == 0);
    i.br   = ($urandom_range(0, 3) == 0);
    i.asrc = 1'($urandom_range(0, 1));
    i.alu  = 3'($urandom_range(0, 7));
    i.rs1  = 5'($urandom_range(0, 7));
    i.rs2  = 5'($urandom_range(0, 7));
    i.rd   = 5'($urandom_range(0, 7));
    return i;
  endfunction

  task automatic apply(input instr_t d, input bit z, input bit r);
    cur  = d;
    zero = z;
    rst  = r;
    bus_w.RegWriteD = d.rw;  bus_n.RegWriteD = d.rw;
    bus_w.ResultSrcD = d.res; bus_n.ResultSrcD = d.res;
    bus_w.MemWriteD = d.mw;  bus_n.MemWriteD = d.mw;
    bus_w.JumpD = d.jmp;     bus_n.JumpD = d.jmp;
    bus_w.BranchD = d.br;    bus_n.BranchD = d.br;
    bus_w.ALUSrcD = d.asrc;  bus_n.ALUSrcD = d.asrc;
    bus_w.ALUControlD = d.alu; bus_n.ALUControlD = d.alu;
    bus_w.Rs1D = d.rs1;      bus_n.Rs1D = d.rs1;
    bus_w.Rs2D = d.rs2;      bus_n.Rs2D = d.rs2;
    bus_w.RdD = d.rd;        bus_n.RdD = d.rd;
    bus_w.ZeroE = z;         bus_n.ZeroE = z;
  endtask

  task automatic check_outputs();
    bit lw, pc;
    lw = exp_lw();
    pc = exp_pcsrc();
    check("ALUSrcE",     bus_w.ALUSrcE,     pipe[0].asrc);
    check("ALUControlE", bus_w.ALUControlE, pipe[0].alu);
    check("PCSrcE",      bus_w.PCSrcE,      pc);
    check("MemWriteM",   bus_w.MemWriteM,   pipe[1].mw);
    check("ResultSrcW",  bus_w.ResultSrcW,  pipe[2].res);
    check("RegWriteW",   bus_w.RegWriteW,   pipe[2].rw);
    check("RdW",         bus_w.RdW,         pipe[2].rd);
    check("ForwardAE",   bus_w.ForwardAE,   exp_fwd(pipe[0].rs1));
    check("ForwardBE",   bus_w.ForwardBE,   exp_fwd(pipe[0].rs2));
    check("StallF",      bus_w.StallF,      lw);
    check("StallD",      bus_w.StallD,      lw);
    check("FlushD",      bus_w.FlushD,      pc);
    check("StallCount",  bus_w.StallCount,  sat(stall_events, 65535));
    check("FlushCount",  bus_w.FlushCount,  sat(flush_events, 65535));
    check("n_RdW",       bus_n.RdW,         pipe[2].rd);
    check("n_ForwardAE", bus_n.ForwardAE,   exp_fwd(pipe[0].rs1));
    check("n_StallCount", bus_n.StallCount, sat(stall_events, 3));
    check("n_FlushCount", bus_n.FlushCount, sat(flush_events, 3));
  endtask

  // Compare against the model, clock once, advance the model, settle 1 ns past the edge.
  task automatic tick();
    bit lw, pc;
    if (model_valid) check_outputs();
    lw = exp_lw();
    pc = exp_pcsrc();
    @(posedge clk);
    if (rst) begin
      pipe[0] = nop_i; pipe[1] = nop_i; pipe[2] = nop_i;
      stall_events = 0;
      flush_events = 0;
      model_valid  = 1'b1;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (lw || pc) ? nop_i : cur;
      if (lw) stall_events++;
      if (pc) flush_events++;
    end
    #1;
  endtask

  task automatic run(input instr_t d, input bit z);
    apply(d, z, 1'b0);
    #4;
    tick();
  endtask

  task automatic do_reset();
    apply(rand_instr(), 1'($urandom_range(0, 1)), 1'b1);
    #4;
    tick();
  endtask

  initial begin
    instr_t add5, use_i, lw_i, beq_i, jl_i;
    int unsigned sat_exp [5];
    sat_exp = '{1, 2, 3, 3, 3};
    nop_i = '{default: 0};
    n_checks = 0; n_errors = 0;
    stall_events = 0; flush_events = 0;
    model_valid = 1'b0;

    // Reset held two cycles with random decode inputs.
    do_reset();
    do_reset();
    apply(nop_i, 1'b0, 1'b0);
    #4;
    check("rst_RegWriteW", bus_w.RegWriteW, 0);
    check("rst_ForwardAE", bus_w.ForwardAE, 0);
    check("rst_StallCount", bus_w.StallCount, 0);
    tick();
    run(nop_i, 1'b0);
    run(nop_i, 1'b0);

    // Forwarding: Memory beats Writeback, then Writeback alone, then x0 never forwards.
    add5 = nop_i; add5.rw = 1; add5.rd = 5;
    use_i = nop_i; use_i.rs1 = 5; use_i.alu = 3'b011;
    do_reset();
    run(add5, 0); run(add5, 0); run(use_i, 0);
    apply(nop_i, 0, 0); #4;
    check("fwd_mem_prio", bus_w.ForwardAE, 2);
    tick();
    do_reset();
    run(add5, 0); run(nop_i, 0); run(use_i, 0);
    apply(nop_i, 0, 0); #4;
    check("fwd_wb", bus_w.ForwardAE, 1);
    tick();
    add5.rd = 0; use_i.rs1 = 0;
    do_reset();
    run(add5, 0); run(use_i, 0);
    apply(nop_i, 0, 0); #4;
    check("fwd_x0", bus_w.ForwardAE, 0);
    tick();

    // Load-use: one stall cycle, bubble in E, then Writeback forwarding.
    lw_i = nop_i; lw_i.rw = 1; lw_i.res = 2'b01; lw_i.rd = 7;
    use_i = nop_i; use_i.rw = 1; use_i.rs2 = 7; use_i.rd = 8; use_i.alu = 3'b101; use_i.asrc = 1;
    do_reset();
    run(lw_i, 0);
    apply(use_i, 0, 0); #4;
    check("lu_stallf", bus_w.StallF, 1);
    check("lu_stalld", bus_w.StallD, 1);
    tick();
    apply(use_i, 0, 0); #4;
    check("lu_stall_once", bus_w.StallF, 0);
    check("lu_bubble_alu", bus_w.ALUControlE, 0);
    check("lu_bubble_src", bus_w.ALUSrcE, 0);
    tick();
    apply(nop_i, 0, 0); #4;
    check("lu_fwdb", bus_w.ForwardBE, 1);
    check("lu_count", bus_w.StallCount, 1);
    tick();

    // Taken branch flushes, untaken does not.
    beq_i = nop_i; beq_i.br = 1; beq_i.alu = 3'b001;
    do_reset();
    run(beq_i, 0);
    apply(nop_i, 1, 0); #4;
    check("br_pcsrc", bus_w.PCSrcE, 1);
    check("br_flushd", bus_w.FlushD, 1);
    tick();
    apply(nop_i, 1, 0); #4;
    check("br_once", bus_w.PCSrcE, 0);
    check("br_count", bus_w.FlushCount, 1);
    tick();
    do_reset();
    run(beq_i, 0);
    apply(nop_i, 0, 0); #4;
    check("nbr_pcsrc", bus_w.PCSrcE, 0);
    check("nbr_flushd", bus_w.FlushD, 0);
    tick();

    // Load and jump in E together with a dependent instruction in D.
    jl_i = nop_i; jl_i.rw = 1; jl_i.res = 2'b01; jl_i.jmp = 1; jl_i.rd = 3;
    use_i = nop_i; use_i.rs1 = 3; use_i.alu = 3'b110;
    do_reset();
    run(jl_i, 0);
    apply(use_i, 0, 0); #4;
    check("sim_stall", bus_w.StallF, 1);
    check("sim_pcsrc", bus_w.PCSrcE, 1);
    tick();
    apply(nop_i, 0, 0); #4;
    check("sim_bubble", bus_w.ALUControlE, 0);
    check("sim_stallcnt", bus_w.StallCount, 1);
    check("sim_flushcnt", bus_w.FlushCount, 1);
    tick();

    // Saturation of the 2-bit counter over five load-use stalls.
    use_i = nop_i; use_i.rs1 = 7;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run(lw_i, 0);
      run(use_i, 0);
      check("sat_n", bus_n.StallCount, sat_exp[i]);
    end

    // Random traffic with occasional mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      apply(rand_instr(), 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      #4;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
